// File: rtl/ryu_palette_pkg.sv
// Shared types and constants for the palette encoder.
// Covers the colour struct, the data widths and the FSM state encoding.
package ryu_palette_pkg;

    localparam int          PAL_ENTRIES             = 16;
    localparam int          IDX_W                   = 4;
    localparam int          DIST_W                  = 6;
    localparam logic [11:0] DEFAULT_TRANSPARENT_KEY = 12'hF0F;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    function automatic logic [3:0] absdiff4(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/ryu_color_dist.sv
// Combinational sum of absolute channel differences between two 12-bit colours.
// The result is at most 45, so it fits in 6 bits without overflow.
module ryu_color_dist
    import ryu_palette_pkg::*;
(
    input  rgb12_t              a_i,
    input  rgb12_t              b_i,
    output logic [DIST_W-1:0]   dist_o
);

    // Widen each 4-bit term to 6 bits before summing.
    always_comb begin
        dist_o = {2'b00, absdiff4(a_i.r, b_i.r)}
               + {2'b00, absdiff4(a_i.g, b_i.g)}
               + {2'b00, absdiff4(a_i.b, b_i.b)};
    end

endmodule

// File: rtl/ryu_palette_encoder.sv
// Nearest-colour encoder: scans a 16-entry runtime palette one entry per clock
// and returns the index with the smallest distance (lowest index wins ties).
module ryu_palette_encoder
    import ryu_palette_pkg::*;
#(
    parameter bit          SKIP_TRANSPARENT = 1'b1,
    parameter logic [11:0] TRANSPARENT_KEY  = DEFAULT_TRANSPARENT_KEY
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [11:0]       pal_wdata,
    input  logic              in_valid,
    input  logic [11:0]       in_rgb,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DIST_W-1:0] out_dist
);

    localparam logic [IDX_W-1:0] K_START = SKIP_TRANSPARENT ? 4'd1 : 4'd0;

    rgb12_t              pal_q [PAL_ENTRIES];
    enc_state_e          state_q;
    rgb12_t              rgb_q;
    logic [IDX_W-1:0]    k_q;
    logic [IDX_W-1:0]    best_idx_q;
    logic [DIST_W-1:0]   best_dist_q;
    logic                out_valid_q;
    logic [IDX_W-1:0]    out_index_q;
    logic [DIST_W-1:0]   out_dist_q;
    logic [DIST_W-1:0]   dist_d;
    logic                better_d;

    // Palette registers; writes land at the next edge regardless of FSM state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                pal_q[i] <= rgb12_t'(12'h000);
            end
        end else if (pal_we) begin
            pal_q[pal_addr] <= rgb12_t'(pal_wdata);
        end
    end

    ryu_color_dist u_dist (
        .a_i    (rgb_q),
        .b_i    (pal_q[k_q]),
        .dist_o (dist_d)
    );

    assign better_d = (dist_d < best_dist_q);

    // Encoder FSM with registered result outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            rgb_q       <= rgb12_t'(12'h000);
            k_q         <= 4'd0;
            best_idx_q  <= 4'd0;
            best_dist_q <= 6'd63;
            out_valid_q <= 1'b0;
            out_index_q <= 4'd0;
            out_dist_q  <= 6'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        rgb_q       <= rgb12_t'(in_rgb);
                        best_idx_q  <= 4'd0;
                        best_dist_q <= 6'd63;
                        if (SKIP_TRANSPARENT && (in_rgb == TRANSPARENT_KEY)) begin
                            best_dist_q <= 6'd0;
                            state_q     <= ST_DONE;
                        end else begin
                            k_q     <= K_START;
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_SCAN: begin
                    if (better_d) begin
                        best_idx_q  <= k_q;
                        best_dist_q <= dist_d;
                    end
                    k_q <= k_q + 4'd1;
                    if (k_q == 4'd15) begin
                        out_valid_q <= 1'b1;
                        out_index_q <= better_d ? k_q : best_idx_q;
                        out_dist_q  <= better_d ? dist_d : best_dist_q;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // The transparent fast path enters here without a result yet.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_index_q <= best_idx_q;
                        out_dist_q  <= best_dist_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_dist  = out_dist_q;

endmodule

// File: tb/tb_ryu_palette_encoder.sv
// Directed bench for ryu_palette_encoder with scoreboard queues; exercises one
// instance with entry 0 skipped and one with a full 16-entry scan.
module tb_ryu_palette_encoder;
    import ryu_palette_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [11:0] pal_wdata = 12'h000;
    logic [11:0] in_rgb = 12'h000;
    logic        in_valid1 = 1'b0, in_valid0 = 1'b0;
    logic        out_ready1 = 1'b0, out_ready0 = 1'b0;
    logic        in_ready1, in_ready0, out_valid1, out_valid0;
    logic [3:0]  out_index1, out_index0;
    logic [5:0]  out_dist1, out_dist0;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    logic [9:0]  q1[$];
    logic [9:0]  q0[$];
    logic [11:0] tb_pal [16];
    logic [11:0] load_pal [16] = '{12'hF0F, 12'hB98, 12'hFFF, 12'h111, 12'hEEC, 12'h753,
                                   12'hDCB, 12'h876, 12'hFB9, 12'hF20, 12'hBA9, 12'hC97,
                                   12'hEA8, 12'hA76, 12'hFDA, 12'hC10};

    ryu_palette_encoder #(.SKIP_TRANSPARENT(1'b1), .TRANSPARENT_KEY(12'hF0F)) dut (
        .Clk(Clk), .Reset(Reset), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .in_valid(in_valid1), .in_rgb(in_rgb), .in_ready(in_ready1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_index(out_index1), .out_dist(out_dist1)
    );

    ryu_palette_encoder #(.SKIP_TRANSPARENT(1'b0), .TRANSPARENT_KEY(12'hF0F)) dut0 (
        .Clk(Clk), .Reset(Reset), .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .in_valid(in_valid0), .in_rgb(in_rgb), .in_ready(in_ready0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_index(out_index0), .out_dist(out_dist0)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int chan_abs(input logic [3:0] a, input logic [3:0] b);
        int x;
        x = int'(a) - int'(b);
        return (x < 0) ? -x : x;
    endfunction

    // Reference nearest-colour search over the bench copy of the palette.
    function automatic logic [9:0] model(input logic [11:0] c, input bit skip);
        int best;
        int bi;
        int d;
        best = 63;
        bi = 0;
        if (skip && c == 12'hF0F) return 10'd0;
        for (int k = (skip ? 1 : 0); k < 16; k++) begin
            d = chan_abs(c[11:8], tb_pal[k][11:8]) + chan_abs(c[7:4], tb_pal[k][7:4])
              + chan_abs(c[3:0], tb_pal[k][3:0]);
            if (d < best) begin
                best = d;
                bi = k;
            end
        end
        return {4'(bi), 6'(best)};
    endfunction

    task automatic pal_write(input logic [3:0] a, input logic [11:0] d);
        pal_we = 1'b1;
        pal_addr = a;
        pal_wdata = d;
        tick();
        pal_we = 1'b0;
        tb_pal[a] = d;
    endtask

    task automatic encode(input bit sel, input logic [11:0] rgb, input logic [9:0] exp,
                          input int lat, input int hold);
        int         cyc;
        logic [3:0] idx;
        logic [5:0] dst;
        logic [9:0] e;
        if (sel) q1.push_back(exp); else q0.push_back(exp);
        in_rgb = rgb;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b0 | 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        chk("busy_in_ready", sel ? in_ready1 : in_ready0, 12'h0);
        cyc = 0;
        while (!(sel ? out_valid1 : out_valid0) && cyc < 40) begin
            // A colour offered while busy must be dropped.
            if (cyc == 3) begin
                in_rgb = ~rgb;
                if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
            end
            tick();
            in_valid1 = 1'b0;
            in_valid0 = 1'b0;
            cyc++;
        end
        chk("latency", 12'(cyc), 12'(lat));
        idx = sel ? out_index1 : out_index0;
        dst = sel ? out_dist1 : out_dist0;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("hold_valid", sel ? out_valid1 : out_valid0, 12'h1);
            chk("hold_index", sel ? out_index1 : out_index0, 12'(idx));
            chk("hold_dist", sel ? out_dist1 : out_dist0, 12'(dst));
            chk("hold_in_ready", sel ? in_ready1 : in_ready0, 12'h0);
        end
        e = sel ? q1.pop_front() : q0.pop_front();
        chk("out_index", 12'(idx), 12'(e[9:6]));
        chk("out_dist", 12'(dst), 12'(e[5:0]));
        if (sel) out_ready1 = 1'b1; else out_ready0 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        out_ready0 = 1'b0;
        chk("post_valid", sel ? out_valid1 : out_valid0, 12'h0);
        chk("post_in_ready", sel ? in_ready1 : in_ready0, 12'h1);
        chk("post_index_held", sel ? out_index1 : out_index0, 12'(idx));
    endtask

    initial begin
        logic [11:0] c;
        for (int i = 0; i < 16; i++) tb_pal[i] = 12'h000;
        #2;
        chk("rst_in_ready", in_ready1, 12'h1);
        chk("rst_out_valid", out_valid1, 12'h0);
        chk("rst_out_index", out_index1, 12'h0);
        chk("rst_out_dist", out_dist1, 12'h0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        encode(1'b1, 12'h123, {4'd1, 6'd6}, 15, 0);
        encode(1'b0, 12'h123, {4'd0, 6'd6}, 16, 0);

        for (int i = 0; i < 16; i++) pal_write(4'(i), load_pal[i]);

        encode(1'b1, 12'hFFF, {4'd2, 6'd0}, 15, 0);
        encode(1'b0, 12'hFFF, {4'd2, 6'd0}, 16, 0);
        encode(1'b1, 12'hF10, {4'd9, 6'd1}, 15, 0);
        encode(1'b1, 12'hF0F, {4'd0, 6'd0}, 1, 5);
        encode(1'b0, 12'hF0F, {4'd0, 6'd0}, 16, 0);
        for (int i = 0; i < 4; i++) begin
            c = 12'($urandom_range(0, 4095));
            encode(1'b1, c, model(c, 1'b1), (c == 12'hF0F) ? 1 : 15, 0);
            encode(1'b0, c, model(c, 1'b0), 16, 0);
        end

        // Reset in the middle of a scan.
        in_rgb = 12'h5A5;
        in_valid1 = 1'b1;
        in_valid0 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in_valid0 = 1'b0;
        repeat (8) tick();
        #2 Reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid1, 12'h0);
        chk("midrst_in_ready", in_ready1, 12'h1);
        chk("midrst_in_ready0", in_ready0, 12'h1);
        chk("midrst_out_index", out_index1, 12'h0);
        for (int i = 0; i < 16; i++) tb_pal[i] = 12'h000;
        tick();
        Reset = 1'b0;
        tick();
        encode(1'b1, 12'h111, {4'd1, 6'd3}, 15, 0);
        encode(1'b0, 12'h111, model(12'h111, 1'b0), 16, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
